// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: MEM_PARITY_EN (per-word even parity column).
package mem_pkg;

  localparam int unsigned WordWidth = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StDone    = 2'd2,
    StRelease = 2'd3
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word array: writes are clocked, reads are combinational so the
// responder can capture the word at its commit edge.
// With MEM_PARITY_EN defined, an even-parity bit is kept beside each word.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned AddrW = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     addr_i,
  input  logic [WordWidth-1:0] wdata_i,
  output logic [WordWidth-1:0] rdata_o
`ifdef MEM_PARITY_EN
  ,
  input  logic                 par_flip_i,
  output logic                 par_err_o
`endif
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [WordWidth-1:0] mem_q [Depth];

  // Word storage; contents are deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

`ifdef MEM_PARITY_EN
  logic par_q [Depth];

  // Parity column; par_flip_i corrupts the stored bit for fault testing.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      par_q[addr_i] <= (^wdata_i) ^ par_flip_i;
    end
  end

  assign par_err_o = ^{rdata_o, par_q[addr_i]};
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the control unit's active-low data-memory strobes.
// Serves one command at a time after WAIT_STATES extra cycles, then waits for
// both strobes to return high so a held strobe is not re-executed.
// Optional feature macro: MEM_PARITY_EN (adds parityInject and parity checks).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        stall,
  output logic        memError
`ifdef MEM_PARITY_EN
  ,
  input  logic        parityInject
`endif
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WordWidth-1:0]  wdata_q, wdata_d;
  op_e                   op_q, op_d;
  logic [WordWidth-1:0]  read_data_q, read_data_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic                  inject_q, inject_d;

  logic                  mem_we;
  logic [WordWidth-1:0]  mem_rdata;
  logic                  par_err;
  logic [31:0]           addr_hi;
  logic                  addr_bad;

  // Any bit above the word-address field, or a non-word-aligned byte address.
  assign addr_hi  = address >> (ADDR_W + 2);
  assign addr_bad = (|address[1:0]) | (|addr_hi);

  mem_array #(
    .AddrW (ADDR_W)
  ) u_mem_array (
    .clk_i      (clock),
    .we_i       (mem_we),
    .addr_i     (addr_q),
    .wdata_i    (wdata_q),
    .rdata_o    (mem_rdata)
`ifdef MEM_PARITY_EN
    ,
    .par_flip_i (inject_q),
    .par_err_o  (par_err)
`endif
  );

`ifdef MEM_PARITY_EN
  assign inject_d = parityInject;
`else
  assign inject_d = 1'b0;
  assign par_err  = 1'b0;
`endif

  // Next-state, command latching and commit decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    read_data_d = read_data_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!memRead && !memWrite) begin
          error_d = 1'b1;
          state_d = StRelease;
        end else if (memRead != memWrite) begin
          if (addr_bad) begin
            error_d = 1'b1;
            ready_d = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = address[ADDR_W+1:2];
            wdata_d = writeData;
            op_d    = memWrite ? OpRead : OpWrite;
            cnt_d   = 4'(WAIT_STATES);
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          if (op_q == OpWrite) begin
            mem_we = 1'b1;
          end else begin
            read_data_d = mem_rdata;
            error_d     = par_err;
          end
          ready_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StRelease;
      end
      StRelease: begin
        if (memRead && memWrite) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any in-flight command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= OpRead;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      inject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      inject_q    <= (state_q == StIdle) ? inject_d : inject_q;
    end
  end

  assign readData = read_data_q;
  assign memReady = ready_q;
  assign memError = error_q;
  assign stall    = (state_q == StAccess);

endmodule
